// File: rtl/bus_arbiter_n_if.sv
// bus_arbiter_n_if: requester-side and memory-side bus bundle for the N-master arbiter
interface bus_arbiter_n_if #(parameter int NUM_MASTERS = 2);
  localparam int IW = $clog2(NUM_MASTERS);
  logic [NUM_MASTERS-1:0] m_valid;
  logic [NUM_MASTERS-1:0] m_ready;
  logic [32*NUM_MASTERS-1:0] m_addr;
  logic [32*NUM_MASTERS-1:0] m_wdata;
  logic [4*NUM_MASTERS-1:0] m_wstrb;
  logic [31:0] m_rdata;
  logic s_valid;
  logic s_ready;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0] s_wstrb;
  logic [31:0] s_rdata;
  logic [IW-1:0] grant_id;
  logic bus_err;
  // environment view: the requesting masters plus the external memory
  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant_id, bus_err
  );
  // arbiter view
  modport slave (
    input m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant_id, bus_err
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master to 1-slave valid/ready arbiter with fixed/round-robin priority and slave timeout
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 0,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input logic clk,
  input logic resetn,
  bus_arbiter_n_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, ptr_q, ptr_d, win;
  logic [IW:0] cand, nxt;
  logic [31:0] cnt_q, cnt_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic bus_err_q, bus_err_d;
  // winner scan: walk offsets from farthest to nearest so the highest-priority requester overwrites last
  always_comb begin
    win = '0;
    cand = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = (RR_MODE != 0) ? {1'b0, ptr_q} + (IW+1)'(i) : (IW+1)'(i);
      cand = (cand >= (IW+1)'(NUM_MASTERS)) ? cand - (IW+1)'(NUM_MASTERS) : cand;
      if (bus.m_valid[cand[IW-1:0]]) win = cand[IW-1:0];
    end
  end
  // next state, request latch, completion and timeout handling
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bus_err_d = 1'b0;
    bus.m_ready = '0;
    bus.m_rdata = bus.s_rdata;
    nxt = {1'b0, win} + (IW+1)'(1);
    if (state_q == IDLE) begin
      if (|bus.m_valid) begin
        state_d = BUSY;
        grant_d = win;
        cnt_d = '0;
        addr_d = bus.m_addr[32*win +: 32];
        wdata_d = bus.m_wdata[32*win +: 32];
        wstrb_d = bus.m_wstrb[4*win +: 4];
        ptr_d = (RR_MODE == 0) ? ptr_q : (nxt == (IW+1)'(NUM_MASTERS)) ? '0 : nxt[IW-1:0];
      end
    end else if (bus.s_ready) begin
      bus.m_ready[grant_q] = 1'b1;
      state_d = IDLE;
    end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
      bus.m_ready[grant_q] = 1'b1;
      bus.m_rdata = ERR_RDATA;
      bus_err_d = 1'b1;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end
  // state and request registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus.s_valid = (state_q == BUSY);
  assign bus.s_addr = addr_q;
  assign bus.s_wdata = wdata_q;
  assign bus.s_wstrb = wstrb_q;
  assign bus.grant_id = grant_q;
  assign bus.bus_err = bus_err_q;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: round-robin (timeout 8) and fixed-priority (no timeout) arbiters against a transaction model
module tb_bus_arbiter_n;
  localparam int N = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;
  bus_arbiter_n_if #(.NUM_MASTERS(N)) if_rr ();
  bus_arbiter_n_if #(.NUM_MASTERS(N)) if_fp ();
  bus_arbiter_n #(.NUM_MASTERS(N), .RR_MODE(1), .TIMEOUT(8), .ERR_RDATA(ERR)) dut_rr (.clk(clk), .resetn(resetn), .bus(if_rr));
  bus_arbiter_n #(.NUM_MASTERS(N), .RR_MODE(0), .TIMEOUT(0), .ERR_RDATA(ERR)) dut_fp (.clk(clk), .resetn(resetn), .bus(if_fp));
  logic [N-1:0] mv [2];
  logic [32*N-1:0] ma [2];
  logic [32*N-1:0] mw [2];
  logic [4*N-1:0] ms [2];
  logic sr [2];
  logic [31:0] sd [2];
  assign if_rr.m_valid = mv[0];
  assign if_rr.m_addr = ma[0];
  assign if_rr.m_wdata = mw[0];
  assign if_rr.m_wstrb = ms[0];
  assign if_rr.s_ready = sr[0];
  assign if_rr.s_rdata = sd[0];
  assign if_fp.m_valid = mv[1];
  assign if_fp.m_addr = ma[1];
  assign if_fp.m_wdata = mw[1];
  assign if_fp.m_wstrb = ms[1];
  assign if_fp.s_ready = sr[1];
  assign if_fp.s_rdata = sd[1];
  logic [N-1:0] o_mr [2];
  logic [31:0] o_rd [2];
  logic [31:0] o_sa [2];
  logic [31:0] o_sw [2];
  logic [3:0] o_ss [2];
  logic o_sv [2];
  logic o_be [2];
  logic [1:0] o_gid [2];
  assign o_mr[0] = if_rr.m_ready;
  assign o_rd[0] = if_rr.m_rdata;
  assign o_sa[0] = if_rr.s_addr;
  assign o_sw[0] = if_rr.s_wdata;
  assign o_ss[0] = if_rr.s_wstrb;
  assign o_sv[0] = if_rr.s_valid;
  assign o_be[0] = if_rr.bus_err;
  assign o_gid[0] = if_rr.grant_id;
  assign o_mr[1] = if_fp.m_ready;
  assign o_rd[1] = if_fp.m_rdata;
  assign o_sa[1] = if_fp.s_addr;
  assign o_sw[1] = if_fp.s_wdata;
  assign o_ss[1] = if_fp.s_wstrb;
  assign o_sv[1] = if_fp.s_valid;
  assign o_be[1] = if_fp.bus_err;
  assign o_gid[1] = if_fp.grant_id;
  // transaction-level reference: who holds the bus, for how many cycles, and what was latched
  int busy [2];
  int g [2];
  int ptr [2];
  int wn [2];
  bit ep [2];
  bit dn [2];
  logic [31:0] la [2];
  logic [31:0] lw [2];
  logic [3:0] ls [2];
  int rr_m [2] = '{1, 0};
  int to_m [2] = '{8, 0};
  int ready_mode;
  int req_mode;
  logic [31:0] fix_rd;
  int gq [$];
  int n_cmp = 0;
  int n_fail = 0;
  function automatic int pick(int d);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (rr_m[d] != 0) ? (ptr[d] + k) % N : k;
      if (mv[d][j]) return j;
    end
    return -1;
  endfunction
  task automatic chk(string tag, int d, logic [31:0] o, logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, o, e);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; g[d] = 0; ptr[d] = 0; wn[d] = 0; ep[d] = 0; dn[d] = 0;
      la[d] = '0; lw[d] = '0; ls[d] = '0;
    end
  endtask
  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_s_valid", d, o_sv[d], 0);
      chk("rst_m_ready", d, o_mr[d], 0);
      chk("rst_s_addr", d, o_sa[d], 0);
      chk("rst_s_wdata", d, o_sw[d], 0);
      chk("rst_s_wstrb", d, o_ss[d], 0);
      chk("rst_grant", d, o_gid[d], 0);
      chk("rst_bus_err", d, o_be[d], 0);
    end
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask
  // one clock: drive slave at negedge, check mid-cycle, advance model at posedge, update masters at negedge
  task automatic step();
    int j;
    for (int d = 0; d < 2; d++) begin
      sr[d] = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'b0 :
              (ready_mode == 3) ? (busy[d] != 0 && wn[d] == 8) : ($urandom_range(0, 2) == 0);
      sd[d] = (fix_rd != 0) ? fix_rd : $urandom;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      dn[d] = busy[d] != 0 && (sr[d] || (to_m[d] != 0 && wn[d] == to_m[d]));
      chk("s_valid", d, o_sv[d], busy[d]);
      chk("grant_id", d, o_gid[d], g[d]);
      chk("s_addr", d, o_sa[d], la[d]);
      chk("s_wdata", d, o_sw[d], lw[d]);
      chk("s_wstrb", d, o_ss[d], ls[d]);
      chk("m_ready", d, o_mr[d], dn[d] ? (32'd1 << g[d]) : 32'd0);
      chk("bus_err", d, o_be[d], ep[d]);
      if (dn[d]) chk("m_rdata", d, o_rd[d], sr[d] ? sd[d] : ERR);
    end
    if (busy[0] != 0 && wn[0] == 1) gq.push_back(o_gid[0]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      ep[d] = dn[d] && !sr[d];
      if (busy[d] != 0) begin
        if (dn[d]) busy[d] = 0;
        else wn[d]++;
      end else begin
        j = pick(d);
        if (j >= 0) begin
          g[d] = j;
          la[d] = ma[d][32*j +: 32];
          lw[d] = mw[d][32*j +: 32];
          ls[d] = ms[d][4*j +: 4];
          busy[d] = 1;
          wn[d] = 1;
          if (rr_m[d] != 0) ptr[d] = (j + 1) % N;
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (dn[d] && req_mode != 2) mv[d][g[d]] = 1'b0;
      if (req_mode == 1) begin
        for (int i = 0; i < N; i++) begin
          if (!mv[d][i] && $urandom_range(0, 3) == 0) begin
            mv[d][i] = 1'b1;
            ma[d][32*i +: 32] = $urandom;
            mw[d][32*i +: 32] = $urandom;
            ms[d][4*i +: 4] = 4'($urandom);
          end else if (mv[d][i] && !(busy[d] != 0 && g[d] == i) && $urandom_range(0, 15) == 0) begin
            mv[d][i] = 1'b0;
          end
        end
      end
    end
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      mv[d] = '0; ma[d] = '0; mw[d] = '0; ms[d] = '0; sr[d] = 1'b0; sd[d] = '0;
    end
    ready_mode = 1; req_mode = 0; fix_rd = '0;
    do_reset();
    // single master read, zero-wait slave
    fix_rd = 32'h1234_5678;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 4'b0001; ma[d][31:0] = 32'h100; mw[d][31:0] = 32'h55; ms[d][3:0] = 4'h0;
    end
    repeat (4) step();
    fix_rd = '0;
    // round-robin rotation on dut0, fixed priority 1 over 3 on dut1
    do_reset();
    req_mode = 2;
    mv[0] = 4'b1111;
    mv[1] = 4'b1010;
    for (int i = 0; i < N; i++)
      for (int d = 0; d < 2; d++) begin
        ma[d][32*i +: 32] = 32'h1000 * (i + 1);
        mw[d][32*i +: 32] = 32'hA0 + i;
        ms[d][4*i +: 4] = 4'(i);
      end
    gq.delete();
    repeat (10) step();
    for (int k = 0; k < 5; k++) chk("rr_seq", 0, (k < gq.size()) ? gq[k] : -1, k % 4);
    mv[1][1] = 1'b0;
    repeat (6) step();
    // timeout: slave never ready
    do_reset();
    req_mode = 1; ready_mode = 2;
    repeat (30) step();
    // race: ready arrives in the timeout cycle
    fix_rd = 32'hA5A5_A5A5;
    ready_mode = 3;
    repeat (25) step();
    fix_rd = '0;
    // reset in the middle of a waiting access
    req_mode = 2; ready_mode = 2;
    mv[0] = 4'b1111; mv[1] = 4'b1111;
    repeat (3) step();
    chk("busy_before_rst", 0, o_sv[0], 1);
    #2;
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_s_valid", d, o_sv[d], 0);
      chk("async_m_ready", d, o_mr[d], 0);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) step();
    // random traffic and slave latency
    req_mode = 1; ready_mode = 0;
    for (int d = 0; d < 2; d++) mv[d] = '0;
    repeat (400) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_n.md
# bus_arbiter_n

Parametrised N-master to 1-slave arbiter for the core's valid/ready memory bus. It generalises the fixed two-master instruction/data merger to NUM_MASTERS requesters with selectable fixed-priority or round-robin arbitration. It registers the granted request toward the slave and adds a slave-response timeout that completes a hung access with an error word. It sits between the core's instruction/data ports (plus optional DMA or debug masters) and the single external memory port.

## Interface
- NUM_MASTERS, 2: number of requesting masters, 2..16.
- RR_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT, 0: BUSY cycles without s_ready before forced completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out access.
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m_valid  in  NUM_MASTERS  per-master request.
- m_ready  out  NUM_MASTERS  per-master completion pulse.
- m_addr  in  32*NUM_MASTERS  flattened addresses; master i uses bits [32i+31:32i].
- m_wdata  in  32*NUM_MASTERS  flattened write data.
- m_wstrb  in  4*NUM_MASTERS  flattened byte strobes; 0 = read.
- m_rdata  out  32  read data, shared by all masters; qualified by that master's m_ready.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion.
- s_addr / s_wdata  out  32 each  registered request to the slave.
- s_wstrb  out  4  registered byte strobes.
- s_rdata  in  32  slave read data.
- grant_id  out  $clog2(NUM_MASTERS)  index of the current or last granted master.
- bus_err  out  1  one-cycle pulse on a timeout completion.

## Operation
- Two states: IDLE and BUSY.
- IDLE, no m_valid set: remain IDLE; s_valid = 0.
- IDLE, any m_valid set: select winner g, latch m_addr/m_wdata/m_wstrb of g into s_addr/s_wdata/s_wstrb, set grant_id = g, clear the timeout counter, go to BUSY.
- Fixed priority: g = lowest set index.
- Round-robin: search starts at pointer p, wraps modulo NUM_MASTERS. After a grant to g, p ← (g+1) mod NUM_MASTERS; p reset value 0.
- BUSY: s_valid = 1. Slave-side outputs stay stable until completion.
- BUSY completion by s_ready = 1:
  - m_ready[g] = 1 combinationally in the same cycle;
  - m_rdata = s_rdata;
  - next state IDLE.
- BUSY without s_ready: counter increments. When TIMEOUT ≠ 0 and the counter equals TIMEOUT−1 in a cycle with s_ready = 0:
  - m_ready[g] = 1, m_rdata = ERR_RDATA;
  - bus_err pulses that cycle (registered, asserted the following cycle for exactly one cycle);
  - next state IDLE.
- s_ready and timeout in the same cycle: s_ready wins; normal data returned, no bus_err.
- m_ready bits other than g are always 0. In IDLE, m_ready = 0 and m_rdata = s_rdata (don't-care).
- Protocol: masters hold m_valid and request fields until their m_ready. The arbiter ignores request-field changes after latching.
- A master that drops m_valid before grant is simply not selected.
- s_ready while IDLE is ignored.

## Timing
- Reset (resetn low, asynchronous): state IDLE, s_valid 0, s_addr/s_wdata 0, s_wstrb 0, grant_id 0, RR pointer 0, counter 0, bus_err 0, m_ready 0.
- Reset asserted mid-BUSY: aborts immediately; no m_ready is issued for the aborted access.
- Arbitration latency: m_valid seen at edge n gives s_valid high from edge n+1.
- Slave with zero wait (s_ready in first BUSY cycle): m_ready two cycles after m_valid rises.
- One mandatory IDLE cycle between consecutive accesses. Peak throughput: one access per 2 cycles with a zero-wait slave.
- Timeout completion occurs in BUSY cycle TIMEOUT, counting the first BUSY cycle as cycle 1.

## Test plan
- Single master (N=2, RR): m_valid[0]=1, addr 0x100, wstrb 0; slave ready first BUSY cycle with rdata 0x12345678 -> s_valid one cycle, s_addr 0x100, m_ready[0] pulse with m_rdata 0x12345678, m_ready[1] 0.
- Round-robin fairness (N=4, RR_MODE=1): all four m_valid held high, zero-wait slave -> grant_id sequence 0,1,2,3,0; each master gets m_ready once per 8 cycles.
- Fixed priority (N=4, RR_MODE=0): masters 1 and 3 held valid -> master 1 served every access; master 3 served only after m_valid[1] drops.
- Timeout (TIMEOUT=8): slave never ready -> m_ready[g] in BUSY cycle 8, m_rdata 0xDEADBEEF, bus_err high one cycle, state IDLE.
- Race (TIMEOUT=8): s_ready first asserted in BUSY cycle 8 with rdata 0xA5A5A5A5 -> m_rdata 0xA5A5A5A5, no bus_err.
- Reset mid-BUSY: resetn pulsed low during wait -> s_valid 0 asynchronously, no m_ready; after release, a pending request is re-arbitrated from pointer 0.
